// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_t;

    localparam int unsigned NUM_REQ    = 2;
    localparam logic        REQ_ICACHE = 1'b0;
    localparam logic        REQ_DCACHE = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Winner selection between icache and dcache requests.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise icache always wins a tie.
import arb_pkg::*;

module rr_pick (
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic               grant_id,
    output logic               any
);

    assign any = |req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_id = REQ_ICACHE;
        if (req[REQ_ICACHE] && req[REQ_DCACHE])
            grant_id = ~last_grant;
        else if (req[REQ_DCACHE])
            grant_id = REQ_DCACHE;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_id = REQ_ICACHE;
        if (!req[REQ_ICACHE] && req[REQ_DCACHE])
            grant_id = REQ_DCACHE;
    end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: one outstanding burst, AR latched, R routed to the owner.
// Tie-break policy is set by ARB_ROUND_ROBIN_EN (see rr_pick).
import arb_pkg::*;

module axi_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    input  logic [NUM_REQ*3-1:0]          s_arsize,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [NUM_REQ-1:0]            s_rvalid,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic                          s_rlast,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic                          m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    input  logic                          m_axi_arready,
    input  logic                          m_axi_rvalid,
    input  logic                          m_axi_rlast,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    output logic                          m_axi_rready,
    output logic                          grant_id,
    output logic                          protocol_err
);

    arb_state_t            state;
    logic                  last_grant;
    logic [7:0]            beat_cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [7:0]            lat_len;
    logic [2:0]            lat_size;
    logic                  pick_id;
    logic                  pick_any;
    logic                  beat;

    rr_pick u_pick (
        .req        (s_arvalid),
        .last_grant (last_grant),
        .grant_id   (pick_id),
        .any        (pick_any)
    );

    assign beat = m_axi_rvalid && m_axi_rready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant_id     <= 1'b0;
            last_grant   <= 1'b1;
            beat_cnt     <= '0;
            protocol_err <= 1'b0;
            lat_addr     <= '0;
            lat_len      <= '0;
            lat_size     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_axi_rvalid)
                        protocol_err <= 1'b1;
                    if (pick_any) begin
                        grant_id <= pick_id;
                        lat_addr <= pick_id ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
                        lat_len  <= pick_id ? s_arlen[15:8] : s_arlen[7:0];
                        lat_size <= pick_id ? s_arsize[5:3] : s_arsize[2:0];
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_rvalid)
                        protocol_err <= 1'b1;
                    if (m_axi_arready) begin
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (m_axi_rlast) begin
                            // beat_cnt still holds the index of this last beat
                            if (beat_cnt != lat_len)
                                protocol_err <= 1'b1;
                            last_grant <= grant_id;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_arready = '0;
        if (!reset && state == IDLE && pick_any)
            s_arready[pick_id] = 1'b1;
    end

    always_comb begin
        s_rvalid = '0;
        if (state == DATA)
            s_rvalid[grant_id] = m_axi_rvalid;
    end

    assign m_axi_rready  = (state == DATA) && s_rready[grant_id];
    assign m_axi_arvalid = (state == ADDR);
    assign m_axi_araddr  = lat_addr;
    assign m_axi_arlen   = lat_len;
    assign m_axi_arsize  = lat_size;
    assign s_rdata       = m_axi_rdata;
    assign s_rlast       = m_axi_rlast;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter; expected grant order follows ARB_ROUND_ROBIN_EN.
module tb_axi_read_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   s_arvalid;
    logic [127:0] s_araddr;
    logic [15:0]  s_arlen;
    logic [5:0]   s_arsize;
    logic [1:0]   s_arready;
    logic [1:0]   s_rvalid;
    logic [63:0]  s_rdata;
    logic         s_rlast;
    logic [1:0]   s_rready;
    logic         m_axi_arvalid;
    logic [63:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic         m_axi_arready;
    logic         m_axi_rvalid;
    logic         m_axi_rlast;
    logic [63:0]  m_axi_rdata;
    logic         m_axi_rready;
    logic         grant_id;
    logic         protocol_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] a0, a1;
    logic [7:0]  l0, l1;
    logic [2:0]  gexp;

    axi_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clock         (clock),
        .reset         (reset),
        .s_arvalid     (s_arvalid),
        .s_araddr      (s_araddr),
        .s_arlen       (s_arlen),
        .s_arsize      (s_arsize),
        .s_arready     (s_arready),
        .s_rvalid      (s_rvalid),
        .s_rdata       (s_rdata),
        .s_rlast       (s_rlast),
        .s_rready      (s_rready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rready  (m_axi_rready),
        .grant_id      (grant_id),
        .protocol_err  (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Full burst: request, optional AR stall with s_araddr/s_arlen scrambled, then R beats.
    task automatic burst(input string tag, input logic [1:0] req, input logic g,
                         input int ar_wait, input int last_at, input bit toggle, input bit hold);
        logic [63:0] ea;
        logic [7:0]  el;
        logic [2:0]  es;
        logic        exp_rdy;
        int          acc;
        bit          done;
        ea = g ? a1 : a0;
        el = g ? l1 : l0;
        es = g ? 3'd3 : 3'd2;
        s_araddr  = {a1, a0};
        s_arlen   = {l1, l0};
        s_arvalid = req;
        #1;
        chk({tag, ".s_arready"}, s_arready, g ? 2'b10 : 2'b01);
        cycle();
        if (!hold)
            s_arvalid = 2'b00;
        for (int i = 0; i <= ar_wait; i++) begin
            if (i > 0) begin
                s_araddr = ~s_araddr;
                s_arlen  = ~s_arlen;
            end
            if (i == ar_wait)
                m_axi_arready = 1'b1;
            #1;
            chk({tag, ".arvalid"}, m_axi_arvalid, 1'b1);
            chk({tag, ".araddr"}, m_axi_araddr, ea);
            chk({tag, ".arlen"}, m_axi_arlen, el);
            chk({tag, ".arsize"}, m_axi_arsize, es);
            chk({tag, ".grant"}, grant_id, g);
            chk({tag, ".arready_busy"}, s_arready, 2'b00);
            cycle();
        end
        m_axi_arready = 1'b0;
        s_araddr = {a1, a0};
        s_arlen  = {l1, l0};
        chk({tag, ".arvalid_off"}, m_axi_arvalid, 1'b0);
        acc  = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            exp_rdy      = !(toggle && (cyc % 2 == 1));
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'hA0 + 64'(acc);
            m_axi_rlast  = (acc == last_at);
            s_rready     = exp_rdy ? 2'b11 : (g ? 2'b01 : 2'b10);
            #1;
            chk({tag, ".s_rvalid"}, s_rvalid, g ? 2'b10 : 2'b01);
            chk({tag, ".m_rready"}, m_axi_rready, exp_rdy);
            chk({tag, ".s_rdata"}, s_rdata, 64'hA0 + 64'(acc));
            chk({tag, ".s_rlast"}, s_rlast, acc == last_at);
            cycle();
            if (exp_rdy) begin
                if (acc == last_at)
                    done = 1'b1;
                acc++;
            end
        end
        chk({tag, ".completed"}, done, 1'b1);
        chk({tag, ".beats"}, acc, last_at + 1);
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        s_rready     = 2'b00;
        #1;
        chk({tag, ".rready_idle"}, m_axi_rready, 1'b0);
        chk({tag, ".rvalid_idle"}, s_rvalid, 2'b00);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        gexp = 3'b010;
`else
        gexp = 3'b000;
`endif
        a0 = 64'h1000;
        a1 = 64'h2000;
        l0 = 8'd7;
        l1 = 8'd7;
        reset         = 1'b1;
        s_arvalid     = 2'b00;
        s_araddr      = {a1, a0};
        s_arlen       = {l1, l0};
        s_arsize      = {3'd3, 3'd2};
        s_rready      = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rdata   = '0;
        cycle();
        cycle();
        chk("rst.arvalid", m_axi_arvalid, 1'b0);
        chk("rst.rready", m_axi_rready, 1'b0);
        chk("rst.s_arready", s_arready, 2'b00);
        chk("rst.s_rvalid", s_rvalid, 2'b00);
        chk("rst.err", protocol_err, 1'b0);
        chk("rst.grant", grant_id, 1'b0);
        reset = 1'b0;
        #1;

        burst("single_ic", 2'b01, 1'b0, 0, 7, 1'b0, 1'b0);
        chk("single_ic.err", protocol_err, 1'b0);

        pulse_reset();
        l0 = 8'd1;
        l1 = 8'd1;
        burst("tie0", 2'b11, gexp[0], 0, 1, 1'b0, 1'b1);
        burst("tie1", 2'b11, gexp[1], 0, 1, 1'b0, 1'b1);
        burst("tie2", 2'b11, gexp[2], 0, 1, 1'b0, 1'b0);
        chk("tie.err", protocol_err, 1'b0);

        l1 = 8'd3;
        burst("ar_stall", 2'b10, 1'b1, 5, 3, 1'b0, 1'b0);
        chk("ar_stall.err", protocol_err, 1'b0);

        l1 = 8'd7;
        burst("dc_toggle", 2'b10, 1'b1, 0, 7, 1'b1, 1'b0);
        chk("dc_toggle.err", protocol_err, 1'b0);

        l0 = 8'd7;
        burst("early_last", 2'b01, 1'b0, 0, 3, 1'b0, 1'b0);
        chk("early_last.err", protocol_err, 1'b1);
        s_arvalid = 2'b10;
        #1;
        chk("early_last.idle", s_arready, 2'b10);
        s_arvalid = 2'b00;

        // Abandon a burst mid-DATA with a reset pulse.
        pulse_reset();
        s_arvalid = 2'b01;
        cycle();
        m_axi_arready = 1'b1;
        cycle();
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b1;
        s_rready      = 2'b01;
        #1;
        chk("mid.s_rvalid", s_rvalid, 2'b01);
        reset = 1'b1;
        #1;
        chk("mid_rst.s_rvalid", s_rvalid, 2'b00);
        chk("mid_rst.rready", m_axi_rready, 1'b0);
        chk("mid_rst.arvalid", m_axi_arvalid, 1'b0);
        chk("mid_rst.s_arready", s_arready, 2'b00);
        chk("mid_rst.err", protocol_err, 1'b0);
        chk("mid_rst.grant", grant_id, 1'b0);
        m_axi_rvalid = 1'b0;
        s_arvalid    = 2'b00;
        s_rready     = 2'b00;
        cycle();
        reset = 1'b0;
        #1;
        chk("post_rst.err", protocol_err, 1'b0);
        s_arvalid = 2'b10;
        #1;
        chk("post_rst.idle", s_arready, 2'b10);
        s_arvalid = 2'b00;
        #1;

        m_axi_rvalid = 1'b1;
        cycle();
        m_axi_rvalid = 1'b0;
        chk("idle_rvalid.err", protocol_err, 1'b1);
        cycle();
        chk("idle_rvalid.sticky", protocol_err, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001: Parameter ADDR_WIDTH, default 64, AXI/requester address width.
REQ-002: Parameter DATA_WIDTH, default 64, AXI read data width.
REQ-003: clock  input  1  sole clock; all logic on posedge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: s_arvalid  input  2  per-requester burst request; bit0 = icache, bit1 = dcache.
REQ-006: s_araddr  input  2*ADDR_WIDTH  per-requester line address; bits [ADDR_WIDTH-1:0] belong to requester 0.
REQ-007: s_arlen  input  2*8  per-requester burst length minus one.
REQ-008: s_arsize  input  2*3  per-requester beat size.
REQ-009: s_arready  output  2  per-requester request accept strobe.
REQ-010: s_rvalid  output  2  per-requester read beat valid.
REQ-011: s_rdata  output  DATA_WIDTH  broadcast read data.
REQ-012: s_rlast  output  1  broadcast last-beat flag.
REQ-013: s_rready  input  2  per-requester beat accept.
REQ-014: m_axi_arvalid  output  1; m_axi_araddr  output  ADDR_WIDTH; m_axi_arlen  output  8; m_axi_arsize  output  3; all are AXI AR channel outputs.
REQ-015: m_axi_arready, m_axi_rvalid, m_axi_rlast  input  1 each; m_axi_rdata  input  DATA_WIDTH; all are AXI R/AR inputs.
REQ-016: m_axi_rready  output  1  AXI R channel ready.
REQ-017: grant_id  output  1  owner of the current burst; valid outside IDLE.
REQ-018: protocol_err  output  1  sticky error flag.

Function
REQ-019: The FSM SHALL have exactly three states: IDLE, ADDR and DATA. At most one burst SHALL be outstanding.
REQ-020: In IDLE, when any s_arvalid bit is high, the arbiter SHALL pick a winner, assert s_arready[winner] combinationally in that cycle, latch that requester's araddr/arlen/arsize and the winner id, and move to ADDR.
REQ-021: s_arready SHALL be zero in ADDR and DATA, and the non-winner bit SHALL be zero at all times.
REQ-022: In ADDR, m_axi_arvalid SHALL be 1 with the latched values held stable. On m_axi_arvalid && m_axi_arready the FSM SHALL move to DATA. Latency is 1 cycle from the accepting edge to m_axi_arvalid.
REQ-023: In DATA, the R channel SHALL be routed as follows: s_rvalid[grant_id] = m_axi_rvalid, the other s_rvalid bit = 0, m_axi_rready = s_rready[grant_id], and s_rdata/s_rlast pass through. The path is zero-latency combinational.
REQ-024: m_axi_rready SHALL be 0 outside DATA.
REQ-025: An 8-bit beat counter SHALL clear on entry to DATA and increment on each rvalid && rready.
REQ-026: On a beat where rvalid && rready && rlast, the FSM SHALL return to IDLE and the priority state SHALL update. Back-to-back bursts therefore have at least 1 IDLE cycle between them.
REQ-027: protocol_err SHALL set on either of these events: rlast accepted while the beat counter != latched arlen, or m_axi_rvalid high in IDLE or ADDR. It SHALL stay set until reset.
REQ-028: A requester that drops s_arvalid before it is granted SHALL lose arbitration with no side effects.

Reset
REQ-029: Asserting reset in any state, including mid-burst, SHALL force the FSM to IDLE, the beat counter to 0, protocol_err to 0, grant_id to 0 and last_grant to 1. It SHALL deassert m_axi_arvalid, m_axi_rready, s_arready and s_rvalid.
REQ-030: A burst interrupted by reset is abandoned. The block SHALL perform no recovery.

Configuration
REQ-031: Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are valid in IDLE, the grant SHALL go to !last_grant. After reset, requester 0 wins first.
- Undefined: fixed priority SHALL apply, with requester 0 (icache) always winning a tie, and last_grant unused.
- In both builds, a single valid requester SHALL always win.

Structure
REQ-032: Package arb_pkg SHALL hold the arb_state_t enum, NUM_REQ = 2, REQ_ICACHE = 0 and REQ_DCACHE = 1.
REQ-033: Winner selection SHALL be the sub-module rr_pick (inputs: req[1:0], last_grant; outputs: grant_id, any). It contains the macro-dependent logic.

Verification
REQ-034: s_arvalid = 2'b01, araddr0 = 0x1000, arlen0 = 7 -> s_arready = 01 in the same cycle; m_axi_araddr = 0x1000 and arlen = 7 the next cycle; 8 beats delivered to s_rvalid[0] only; then IDLE.
REQ-035: s_arvalid = 2'b11 held across three bursts with ARB_ROUND_ROBIN_EN -> grants 0, 1, 0. Without the macro -> grants 0, 0, 0.
REQ-036: m_axi_arready held low 5 cycles -> m_axi_arvalid held 5 cycles with araddr and arlen stable even if s_araddr changes.
REQ-037: s_rready[1] toggling during a dcache burst -> m_axi_rready mirrors it, no beat lost, beat count reaches 7 at rlast, protocol_err = 0.
REQ-038: rlast on the 4th beat with arlen = 7 -> protocol_err = 1 and the FSM returns to IDLE. Reset pulse mid-DATA -> all outputs 0, FSM in IDLE, protocol_err = 0.
